// File: rtl/memory_line_adapter_pkg.sv
// Shared types and defaults for the line-to-word memory adapter.
package memory_line_adapter_pkg;

  // Transaction sequencing states of the adapter.
  typedef enum logic [1:0] {
    Idle,
    Issue,
    Drain,
    Done
  } MemoryLineAdapterState;

  // Default word bus geometry: a 128-bit line is served as four 32-bit beats.
  localparam int DefaultWordWidth       = 32;
  localparam int DefaultBeatCount       = 4;
  localparam int DefaultMemoryAddrWidth = 30;
  localparam int DefaultMemoryLineWidth = DefaultWordWidth * DefaultBeatCount;

endpackage

// File: rtl/memory_line_adapter.sv
// Serves one line-wide read or write as a pipelined burst of word accesses
// on a narrow word bus. One transaction at a time; read responses return in
// request order and are assembled low beat first into memoryReadValue.
module memory_line_adapter
  import memory_line_adapter_pkg::*;
#(
  parameter int MemoryAddrWidth  = DefaultMemoryAddrWidth,
  parameter int MemoryLineWidth  = DefaultMemoryLineWidth,
  parameter int WordWidth        = DefaultWordWidth,
  localparam int BeatCount       = MemoryLineWidth / WordWidth,
  localparam int BeatIndexWidth  = $clog2(BeatCount),
  localparam int WordAddrWidth   = MemoryAddrWidth + BeatIndexWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MemoryAddrWidth-1:0] memoryAddr,
  input  logic                       memoryEnable,
  input  logic                       memoryIsWrite,
  input  logic [MemoryLineWidth-1:0] memoryWriteValue,
  output logic [MemoryLineWidth-1:0] memoryReadValue,
  output logic                       memoryDone,
  output logic [WordAddrWidth-1:0]   wordAddr,
  output logic                       wordEnable,
  output logic                       wordIsWrite,
  output logic [WordWidth-1:0]       wordWriteValue,
  input  logic                       wordReady,
  input  logic [WordWidth-1:0]       wordReadValue,
  input  logic                       wordReadValid
);

  // Counter values are one bit wider than a beat index so "all beats" is representable.
  localparam logic [BeatIndexWidth:0] LastBeat  = (BeatIndexWidth+1)'(BeatCount - 1);
  localparam logic [BeatIndexWidth:0] FullCount = (BeatIndexWidth+1)'(BeatCount);
  localparam logic [BeatIndexWidth:0] CountOne  = (BeatIndexWidth+1)'(1);

  MemoryLineAdapterState state;
  MemoryLineAdapterState nextState;

  logic [MemoryAddrWidth-1:0] lineAddr;
  logic                       lineIsWrite;
  logic [MemoryLineWidth-1:0] lineData;
  logic [BeatIndexWidth:0]    issueCount;
  logic [BeatIndexWidth:0]    recvCount;
  logic [BeatIndexWidth:0]    recvCountNext;
  logic [BeatIndexWidth-1:0]  nextBeat;
  logic [BeatIndexWidth-1:0]  recvBeat;
  logic                       startRequest;
  logic                       wordAccept;
  logic                       lastAccept;
  logic                       readPhase;
  logic                       respAccept;

  // Next-state decode plus the two outputs that come straight off the state
  // register. A read that finishes issuing normally drains its remaining
  // responses, but skips Drain if the final response lands in the same cycle.
  always_comb begin
    nextState     = state;
    wordEnable    = 1'b0;
    memoryDone    = 1'b0;
    startRequest  = (state == Idle) && memoryEnable;
    wordAccept    = (state == Issue) && wordReady;
    lastAccept    = wordAccept && (issueCount == LastBeat);
    readPhase     = ((state == Issue) || (state == Drain)) && !lineIsWrite;
    respAccept    = readPhase && wordReadValid;
    recvCountNext = respAccept ? (recvCount + CountOne) : recvCount;
    nextBeat      = issueCount[BeatIndexWidth-1:0] + BeatIndexWidth'(1);
    recvBeat      = recvCount[BeatIndexWidth-1:0];

    case (state)
      Idle: begin
        if (memoryEnable) begin
          nextState = Issue;
        end
      end
      Issue: begin
        wordEnable = 1'b1;
        if (lastAccept) begin
          if (lineIsWrite || (recvCountNext == FullCount)) begin
            nextState = Done;
          end else begin
            nextState = Drain;
          end
        end
      end
      Drain: begin
        if (recvCountNext == FullCount) begin
          nextState = Done;
        end
      end
      Done: begin
        memoryDone = 1'b1;
        nextState  = Idle;
      end
      default: begin
        nextState = Idle;
      end
    endcase
  end

  // State register; reset abandons any transaction in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= Idle;
    end else begin
      state <= nextState;
    end
  end

  // Request capture and beat issue. The word bus fields are registered one
  // beat ahead so they are valid the cycle Issue is entered and simply hold
  // while the downstream stalls with wordReady low.
  always_ff @(posedge clk) begin
    if (rst) begin
      lineAddr       <= '0;
      lineIsWrite    <= 1'b0;
      lineData       <= '0;
      issueCount     <= '0;
      wordAddr       <= '0;
      wordIsWrite    <= 1'b0;
      wordWriteValue <= '0;
    end else if (startRequest) begin
      lineAddr       <= memoryAddr;
      lineIsWrite    <= memoryIsWrite;
      lineData       <= memoryWriteValue;
      issueCount     <= '0;
      wordAddr       <= {memoryAddr, {BeatIndexWidth{1'b0}}};
      wordIsWrite    <= memoryIsWrite;
      wordWriteValue <= memoryWriteValue[WordWidth-1:0];
    end else if (wordAccept) begin
      issueCount     <= issueCount + CountOne;
      wordAddr       <= {lineAddr, nextBeat};
      wordWriteValue <= lineData[nextBeat*WordWidth +: WordWidth];
    end
  end

  // Read assembly: each in-order response fills the next word slot, beat 0
  // lowest. The line only changes when a read response arrives, so it holds
  // across writes and idle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      recvCount       <= '0;
      memoryReadValue <= '0;
    end else if (startRequest) begin
      recvCount <= '0;
    end else if (respAccept) begin
      memoryReadValue[recvBeat*WordWidth +: WordWidth] <= wordReadValue;
      recvCount <= recvCountNext;
    end
  end

  // A response with no read outstanding is dropped by the logic above; flag
  // it in simulation because it means the downstream has lost track.
  always_ff @(posedge clk) begin
    if (!rst && wordReadValid) begin
      strayResponse: assert (readPhase)
        else $warning("memory_line_adapter: stray wordReadValid ignored in state %s", state.name());
    end
  end

endmodule
